// File: rtl/sub_chain_acc.sv
// ============================================================================
// Module   : sub_chain_acc (with leaf subtractor sub)
// Brief    : Framed running-difference accumulator driving a 16-bit subtractor.
//            Optional build macro SAT_EN clamps acc on overflow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sub (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] out,
  output logic        ov
);
  assign out = a - b;
  // Signed overflow: operands differ in sign and result sign differs from a.
  assign ov  = (a[15] ^ b[15]) & (out[15] ^ a[15]);
endmodule

module sub_chain_acc #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_first,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             out_ov,
  output logic [CNT_W-1:0] out_cnt
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  state_t           r_state;
  logic [15:0]      r_acc;
  logic             r_ov;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid;

  logic        w_beat;
  logic [15:0] w_sub_out;
  logic        w_sub_ov;
  logic [15:0] w_acc_next;

  sub u_sub (
    .a   (r_acc),
    .b   (in_data),
    .out (w_sub_out),
    .ov  (w_sub_ov)
  );

`ifdef SAT_EN
  // Clamp toward the sign of the current accumulator when the subtract overflows.
  assign w_acc_next = w_sub_ov ? (r_acc[15] ? 16'h8000 : 16'h7FFF) : w_sub_out;
`else
  assign w_acc_next = w_sub_out;
`endif

  assign in_ready  = (r_state != S_DONE) & ~rst;
  assign w_beat    = in_valid & in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_acc;
  assign out_ov    = r_ov;
  assign out_cnt   = r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc       <= 16'h0000;
      r_ov        <= 1'b0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_ACC: begin
          if (w_beat) begin
            // In IDLE every beat opens a frame; in ACC in_first restarts one.
            if (r_state == S_IDLE || in_first) begin
              r_acc <= in_data;
              r_ov  <= 1'b0;
              r_cnt <= c_cnt_one;
            end else begin
              r_acc <= w_acc_next;
              r_ov  <= r_ov | w_sub_ov;
              if (r_cnt != c_cnt_max) r_cnt <= r_cnt + c_cnt_one;
            end
            if (in_last) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= S_ACC;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_sub_chain_acc.sv
// ============================================================================
// Module   : tb_sub_chain_acc
// Brief    : Scoreboard bench for sub_chain_acc (frame-level model, SAT_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sub_chain_acc;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0000;
  logic        in_first = 1'b0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_ov;
  logic [7:0]  out_cnt;

  typedef struct packed {
    logic [15:0] data;
    logic        ov;
    logic [7:0]  cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] frame_q[$];
  bit          in_frame = 1'b0;
  bit          rand_rdy = 1'b0;
  int          tests = 0;
  int          fails = 0;
  int          idle_cyc = 0;

  sub_chain_acc #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_first  (in_first),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ov    (out_ov),
    .out_cnt   (out_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame result from the word list using plain integer arithmetic.
  function automatic exp_t model(input logic [15:0] w[$]);
    exp_t        e;
    int          a;
    int          d;
    logic [15:0] r;
    a = int'($signed(w[0]));
    e.ov = 1'b0;
    for (int i = 1; i < w.size(); i++) begin
      d = a - int'($signed(w[i]));
      if (d > 32767 || d < -32768) begin
        e.ov = 1'b1;
`ifdef SAT_EN
        d = (a < 0) ? -32768 : 32767;
`endif
      end
      r = d[15:0];
      a = int'($signed(r));
    end
    r = a[15:0];
    e.data = r;
    e.cnt  = (w.size() > 255) ? 8'd255 : 8'(w.size());
    return e;
  endfunction

  // Monitor + reference model, evaluated mid-cycle where everything is stable.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      frame_q.delete();
      exp_q.delete();
      in_frame = 1'b0;
      idle_cyc = 0;
    end else begin
      if (out_valid && out_ready) begin
        idle_cyc = 0;
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e.data));
          check("out_ov", 32'(out_ov), 32'(e.ov));
          check("out_cnt", 32'(out_cnt), 32'(e.cnt));
        end
      end else if (exp_q.size() != 0) begin
        idle_cyc++;
        if (idle_cyc == 200) check("result_timeout", 32'(exp_q.size()), 32'd0);
      end
      if (in_valid && in_ready) begin
        if (!in_frame || in_first) frame_q.delete();
        frame_q.push_back(in_data);
        in_frame = 1'b1;
        if (in_last) begin
          exp_q.push_back(model(frame_q));
          frame_q.delete();
          in_frame = 1'b0;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat edge.
  task automatic send(input logic [15:0] d, input logic f, input logic l);
    int n;
    n = 0;
    in_data = d; in_first = f; in_last = l; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  initial begin
    int n;
    int len;
    // Reset state
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_cnt", 32'(out_cnt), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // 1) three-word frame, one-cycle out_valid
    out_ready = 1'b1;
    send(16'h0064, 1, 0); send(16'h001E, 0, 0); send(16'h0014, 0, 1);
    @(negedge clk);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_data", 32'(out_data), 32'h0032);
    @(negedge clk);
    check("t1_valid_drop", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // 2) overflow frame
    send(16'h7FFF, 1, 0); send(16'hFFFF, 0, 1);
    @(negedge clk);
    check("t2_ov", 32'(out_ov), 32'd1);
`ifdef SAT_EN
    check("t2_data", 32'(out_data), 32'h7FFF);
`else
    check("t2_data", 32'(out_data), 32'h8000);
`endif
    @(posedge clk); #1;

    // 3) single-beat frame
    send(16'h1234, 1, 1);
    @(negedge clk);
    check("t3_valid", 32'(out_valid), 32'd1);
    check("t3_cnt", 32'(out_cnt), 32'd1);
    @(posedge clk); #1;

    // 4) stalled output
    out_ready = 1'b0;
    send(16'h0005, 1, 0); send(16'h0003, 0, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_valid_held", 32'(out_valid), 32'd1);
      check("t4_data_stable", 32'(out_data), 32'h0002);
      check("t4_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t4_idle_valid", 32'(out_valid), 32'd0);
    check("t4_idle_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // 5) reset mid-frame
    send(16'h0010, 1, 0); send(16'h0020, 0, 0);
    rst = 1'b1;
    #1;
    check("t5_data_zero", 32'(out_data), 32'd0);
    check("t5_cnt_zero", 32'(out_cnt), 32'd0);
    check("t5_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("t5_ready_release", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    send(16'h0009, 0, 1);
    @(negedge clk);
    check("t5_data", 32'(out_data), 32'h0009);
    @(posedge clk); #1;

    // 6) restart clears ov, then a 300-word frame saturates the count
    send(16'h7FFF, 1, 0); send(16'hFFFF, 0, 0);
    @(negedge clk);
    check("t6_ov_set", 32'(out_ov), 32'd1);
    check("t6_cnt2", 32'(out_cnt), 32'd2);
    @(posedge clk); #1;
    send(16'h0040, 1, 0);
    @(negedge clk);
    check("t6_acc", 32'(out_data), 32'h0040);
    check("t6_ov_clr", 32'(out_ov), 32'd0);
    check("t6_cnt1", 32'(out_cnt), 32'd1);
    @(posedge clk); #1;
    for (int i = 1; i < 300; i++) send(16'($urandom_range(0, 3)), 0, (i == 299));
    @(negedge clk);
    check("t6_cnt_sat", 32'(out_cnt), 32'd255);
    @(posedge clk); #1;

    // Randomized frames with gaps, mid-frame restarts and backpressure
    rand_rdy = 1'b1;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        n = $urandom_range(0, 3);
        if (n == 0) begin
          @(posedge clk); #1;
        end
        send(16'($urandom), (i == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0),
             (i == len - 1));
      end
    end
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    rand_rdy = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

`default_nettype wire
